// File: rtl/cheby_mac_seq.sv
// ============================================================================
//  Module   : cheby_mac_seq
//  Purpose  : Walks the Chebyshev T_k ROM, multiplies each entry by a stored
//             coefficient and emits one rounded Q1.15 sample y = sum c_k*T_k.
//  Options  : define CHEBY_SAT_EN to clamp the result and add the o_sat port.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cheby_mac_seq #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3,
    parameter int N_TERMS = 8,
    parameter int ACC_W   = 35
) (
    input  logic              c_clk,
    input  logic              c_rst_n,
    input  logic              c_start,
    input  logic              i_coef_we,
    input  logic [ADDR_W-1:0] i_coef_addr,
    input  logic [DATA_W-1:0] i_coef_data,
    output logic [ADDR_W-1:0] o_rom_address,
    output logic              c_rom_ce,
    output logic              c_rom_read_en,
    output logic              c_rom_tri_output,
    input  logic [DATA_W-1:0] i_rom_data,
    output logic [DATA_W-1:0] o_result,
    output logic              o_valid,
`ifdef CHEBY_SAT_EN
    output logic              o_sat,
`endif
    output logic              o_busy
);

    localparam int PROD_W = 2 * DATA_W;
    localparam logic [ADDR_W-1:0]       K_LAST   = ADDR_W'(N_TERMS - 1);
    localparam logic [ADDR_W:0]         N_LIMIT  = (ADDR_W+1)'(N_TERMS);
    localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(2 ** (DATA_W - 2));

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [ADDR_W-1:0]         k_q, k_d;
    logic                      drain_q, drain_d;
    logic signed [PROD_W-1:0]  prod_q;
    logic                      prod_vld_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [DATA_W-1:0]  coef_q [2**ADDR_W];
    logic [DATA_W-1:0]         result_q;

    logic signed [PROD_W-1:0]  w_rom_ext;
    logic signed [PROD_W-1:0]  w_coef_ext;
    logic signed [PROD_W-1:0]  w_prod;
    logic signed [ACC_W-1:0]   w_prod_ext;
    logic signed [ACC_W-1:0]   w_rnd;
    logic [DATA_W-1:0]         w_res;
    logic                      w_coef_wr;
    logic                      w_start;
    logic                      w_finish;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge c_clk or negedge c_rst_n) begin
        if (!c_rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        k_d              = k_q;
        drain_d          = drain_q;
        c_rom_ce         = 1'b0;
        c_rom_read_en    = 1'b0;
        c_rom_tri_output = 1'b1;
        o_busy           = 1'b0;
        o_valid          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (c_start) begin
                    state_d = S_FETCH;
                    k_d     = '0;
                end
            end
            S_FETCH: begin
                c_rom_ce         = 1'b1;
                c_rom_read_en    = 1'b1;
                c_rom_tri_output = 1'b0;
                o_busy           = 1'b1;
                if (k_q == K_LAST) begin
                    state_d = S_DRAIN;
                    k_d     = '0;
                    drain_d = 1'b0;
                end else begin
                    k_d = k_q + ADDR_W'(1);
                end
            end
            // Two drain cycles: one for the last product to land in the
            // accumulator, one to round and register the result.
            S_DRAIN: begin
                o_busy = 1'b1;
                if (drain_q) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            S_DONE: begin
                o_valid = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_rom_address = k_q;
    assign w_start       = (state_q == S_IDLE) && c_start;
    assign w_finish      = (state_q == S_DRAIN) && drain_q;
    assign w_coef_wr     = i_coef_we && !o_busy && ({1'b0, i_coef_addr} < N_LIMIT);

    // ------------------------------------------------------------------
    // Multiply / accumulate pipeline
    // ------------------------------------------------------------------
    assign w_rom_ext  = {{DATA_W{i_rom_data[DATA_W-1]}}, i_rom_data};
    assign w_coef_ext = {{DATA_W{coef_q[k_q][DATA_W-1]}}, coef_q[k_q]};
    assign w_prod     = w_rom_ext * w_coef_ext;
    assign w_prod_ext = {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};
    assign w_rnd      = acc_q + RND_HALF;

    always_ff @(posedge c_clk or negedge c_rst_n) begin
        if (!c_rst_n) begin
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
        end else begin
            prod_vld_q <= (state_q == S_FETCH);
            if (state_q == S_FETCH) begin
                prod_q <= w_prod;
            end
            if (w_start) begin
                acc_q <= '0;
            end else if (prod_vld_q) begin
                acc_q <= acc_q + w_prod_ext;
            end
        end
    end

    always_ff @(posedge c_clk or negedge c_rst_n) begin
        if (!c_rst_n) begin
            for (int i = 0; i < 2**ADDR_W; i++) begin
                coef_q[i] <= '0;
            end
        end else if (w_coef_wr) begin
            coef_q[i_coef_addr] <= i_coef_data;
        end
    end

    // ------------------------------------------------------------------
    // Output rounding (round half up) and optional clamp
    // ------------------------------------------------------------------
`ifdef CHEBY_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [ACC_W-1:0] w_r;
    logic                    w_hi;
    logic                    w_lo;
    logic                    sat_q;

    assign w_r  = w_rnd >>> (DATA_W - 1);
    assign w_hi = (w_r > SAT_MAX);
    assign w_lo = (w_r < SAT_MIN);

    always_comb begin
        w_res = DATA_W'(w_r);
        if (w_hi) begin
            w_res = SAT_MAX[DATA_W-1:0];
        end else if (w_lo) begin
            w_res = SAT_MIN[DATA_W-1:0];
        end
    end

    always_ff @(posedge c_clk or negedge c_rst_n) begin
        if (!c_rst_n) begin
            sat_q <= 1'b0;
        end else if (w_finish) begin
            sat_q <= w_hi || w_lo;
        end
    end

    assign o_sat = sat_q;
`else
    assign w_res = DATA_W'(w_rnd >>> (DATA_W - 1));
`endif

    always_ff @(posedge c_clk or negedge c_rst_n) begin
        if (!c_rst_n) begin
            result_q <= '0;
        end else if (w_finish) begin
            result_q <= w_res;
        end
    end

    assign o_result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_cheby_mac_seq.sv
// ============================================================================
//  Module   : tb_cheby_mac_seq
//  Purpose  : Directed and randomized checks of cheby_mac_seq against a
//             plain-arithmetic model of y = round(sum c_k*T_k).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cheby_mac_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        coef_we = 1'b0;
    logic [2:0]  coef_addr = '0;
    logic [15:0] coef_data = '0;
    logic [2:0]  rom_addr;
    logic        rom_ce, rom_rd, rom_tri;
    logic [15:0] rom_data;
    logic [15:0] result;
    logic        valid, busy;
`ifdef CHEBY_SAT_EN
    logic        sat;
`endif

    int n_pass  = 0;
    int n_total = 0;

    logic signed [15:0] rom_m  [8];
    logic signed [15:0] coef_m [8];
    logic [15:0]        exp_y;
    bit                 exp_sat;

    always #5 clk = ~clk;

    assign rom_data = rom_m[rom_addr];

    cheby_mac_seq dut (
        .c_clk            (clk),
        .c_rst_n          (rst_n),
        .c_start          (start),
        .i_coef_we        (coef_we),
        .i_coef_addr      (coef_addr),
        .i_coef_data      (coef_data),
        .o_rom_address    (rom_addr),
        .c_rom_ce         (rom_ce),
        .c_rom_read_en    (rom_rd),
        .c_rom_tri_output (rom_tri),
        .i_rom_data       (rom_data),
        .o_result         (result),
        .o_valid          (valid),
`ifdef CHEBY_SAT_EN
        .o_sat            (sat),
`endif
        .o_busy           (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference: exact integer dot product, round half up, clamp or wrap.
    task automatic model();
        longint acc = 0;
        longint r;
        for (int k = 0; k < 8; k++) begin
            acc += longint'(rom_m[k]) * longint'(coef_m[k]);
        end
        r = (acc + 16384) >>> 15;
        exp_sat = 1'b0;
`ifdef CHEBY_SAT_EN
        if (r > 32767) begin
            r = 32767;
            exp_sat = 1'b1;
        end else if (r < -32768) begin
            r = -32768;
            exp_sat = 1'b1;
        end
`endif
        exp_y = r[15:0];
    endtask

    task automatic wr_coef(input int idx, input logic [15:0] d);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = idx[2:0];
        coef_data = d;
        @(negedge clk);
        coef_we   = 1'b0;
        coef_m[idx] = d;
    endtask

    task automatic clear_coefs();
        for (int k = 0; k < 8; k++) wr_coef(k, 16'h0000);
    endtask

    // Runs one sample. With disturb set, extra starts (during FETCH and DONE)
    // and a coefficient write during FETCH are issued; all must be ignored.
    task automatic do_run(input string tag, input bit disturb);
        int lat = -1;
        int nvalid = 0;
        bit seq_ok = 1'b1;
        model();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i < 8)
                seq_ok &= (rom_addr == i[2:0]) && rom_ce && rom_rd && !rom_tri && busy;
            else if (i < 10)
                seq_ok &= !rom_ce && rom_tri && busy;
            else if (i > 10)
                seq_ok &= !busy && !rom_ce;
            if (valid) begin
                nvalid++;
                if (lat < 0) lat = i;
            end
            start     = disturb && (i == 3 || i == 10);
            coef_we   = disturb && (i == 3);
            coef_addr = 3'd0;
            coef_data = 16'h1234;
            @(negedge clk);
        end
        start   = 1'b0;
        coef_we = 1'b0;
        chk({tag, "_seq"}, 32'(seq_ok), 32'd1);
        chk({tag, "_latency"}, lat, 10);
        chk({tag, "_nvalid"}, nvalid, 1);
        chk({tag, "_result"}, result, exp_y);
`ifdef CHEBY_SAT_EN
        chk({tag, "_sat"}, 32'(sat), 32'(exp_sat));
`endif
    endtask

    initial begin
        int nvalid;
        for (int k = 0; k < 8; k++) coef_m[k] = '0;
        rom_m[0] = 16'h7FFF; rom_m[1] = 16'hF000; rom_m[2] = 16'h8400; rom_m[3] = 16'h2EFF;
        rom_m[4] = 16'h703F; rom_m[5] = 16'hB4F0; rom_m[6] = 16'hA284; rom_m[7] = 16'h626E;

        #23;
        chk("rst_ce",    32'(rom_ce),  32'd0);
        chk("rst_tri",   32'(rom_tri), 32'd1);
        chk("rst_rd",    32'(rom_rd),  32'd0);
        chk("rst_busy",  32'(busy),    32'd0);
        chk("rst_valid", 32'(valid),   32'd0);
        chk("rst_res",   result,       32'h0);
        chk("rst_addr",  rom_addr,     32'h0);
`ifdef CHEBY_SAT_EN
        chk("rst_sat",   32'(sat),     32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        wr_coef(0, 16'h7FFF);
        do_run("c0", 1'b0);
        chk("c0_const", result, 32'h7FFE);

        clear_coefs();
        wr_coef(1, 16'h4000);
        do_run("c1", 1'b0);
        chk("c1_const", result, 32'hF800);

        clear_coefs();
        wr_coef(0, 16'h7FFF);
        wr_coef(3, 16'h7FFF);
        do_run("c03", 1'b0);
`ifdef CHEBY_SAT_EN
        chk("c03_const", result, 32'h7FFF);
`else
        chk("c03_const", result, 32'hAEFD);
`endif

        do_run("dist", 1'b1);
`ifdef CHEBY_SAT_EN
        chk("dist_const", result, 32'h7FFF);
`else
        chk("dist_const", result, 32'hAEFD);
`endif

        // Asynchronous reset while address 4 is on the bus.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_addr4", rom_addr, 32'd4);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ce",    32'(rom_ce),  32'd0);
        chk("abort_tri",   32'(rom_tri), 32'd1);
        chk("abort_busy",  32'(busy),    32'd0);
        chk("abort_addr",  rom_addr,     32'd0);
        chk("abort_res",   result,       32'h0);
        for (int k = 0; k < 8; k++) coef_m[k] = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nvalid = 0;
        for (int i = 0; i < 14; i++) begin
            if (valid) nvalid++;
            @(negedge clk);
        end
        chk("abort_novalid", nvalid, 0);
        do_run("post_abort", 1'b0);
        chk("post_abort_const", result, 32'h0);

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 8; k++) begin
                rom_m[k] = 16'($urandom);
                wr_coef(k, (r < 3) ? 16'($signed(16'($urandom)) >>> 3) : 16'($urandom));
            end
            do_run($sformatf("rnd%0d", r), r[0]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cheby_mac_seq.md
Name: cheby_mac_seq

Overview:
- Downstream consumer of the Chebyshev T-value ROM (T_k(x) entries, 16-bit signed Q1.15, 3-bit address).
- On a start pulse, walks the ROM addresses 0..N_TERMS-1 and multiplies each returned T_k by a locally stored coefficient c_k.
- Accumulates the products and emits one rounded Q1.15 filter sample, y = sum c_k*T_k(x).
- Owns all ROM control lines: address, chip enable, read enable and tristate.

Parameters:
- DATA_W, 16: ROM data and coefficient width (signed Q1.15).
- ADDR_W, 3: ROM address width.
- N_TERMS, 8: number of terms evaluated. Must be ≤ 2^ADDR_W.
- ACC_W, 35: accumulator width. Must be ≥ 2*DATA_W + clog2(N_TERMS).

Ports:
- c_clk, in, 1: clock, rising edge.
- c_rst_n, in, 1: asynchronous active-low reset.
- c_start, in, 1: single-cycle request to compute one sample.
- i_coef_we, in, 1: coefficient write strobe.
- i_coef_addr, in, ADDR_W: coefficient index.
- i_coef_data, in, DATA_W: coefficient value (Q1.15).
- o_rom_address, out, ADDR_W: ROM address.
- c_rom_ce, out, 1: ROM chip enable.
- c_rom_read_en, out, 1: ROM read enable.
- c_rom_tri_output, out, 1: ROM output tristate (1 = high-Z).
- i_rom_data, in, DATA_W: ROM data (combinational from address).
- o_result, out, DATA_W: filter output (Q1.15).
- o_valid, out, 1: one-cycle pulse; o_result is new.
- o_busy, out, 1: computation in progress.

Behaviour:
- Reset values (asynchronous): o_rom_address = 0, c_rom_ce = 0, c_rom_read_en = 0, c_rom_tri_output = 1, o_result = 0, o_valid = 0, o_busy = 0, accumulator = 0, all coefficients = 0, FSM = IDLE.
- Reset mid-operation aborts immediately. No o_valid is produced for the aborted run.
- FSM states:
  - IDLE: ROM deselected (ce = 0, read_en = 0, tri = 1).
  - FETCH: ce = 1, read_en = 1, tri = 0; o_rom_address = k.
  - DRAIN: ce = 0, tri = 1; last product accumulates.
  - DONE: o_valid = 1 for one cycle, then return to IDLE.
- Transitions: IDLE --c_start--> FETCH (k=0, accumulator cleared); FETCH stays while k < N_TERMS-1, k increments each cycle; FETCH --k = N_TERMS-1--> DRAIN; DRAIN --> DONE; DONE --> IDLE.
- Pipeline:
  - During FETCH cycle k, register p = i_rom_data * coef[k] (signed, full 2*DATA_W).
  - Next cycle, acc += sign-extended p.
- Latency: c_start sampled at edge E0. Address k is driven in the cycle after edge E(k). o_valid is high in the cycle after edge E(N_TERMS+2), i.e. 10 cycles for the default N_TERMS = 8.
- o_busy = 1 in FETCH and DRAIN; o_busy = 0 in IDLE and DONE.
- c_start is ignored unless the FSM is in IDLE.
- A c_start during DONE is ignored; the next start is accepted from IDLE only.
- Coefficient writes are accepted only when o_busy = 0. Writes while busy are dropped, so a running sample always uses a stable coefficient set.
- Output scaling:
  - r = (acc + 2^(DATA_W-2)) >>> (DATA_W-1), i.e. round half up.
  - o_result = r[DATA_W-1:0], subject to the optional saturation below.
  - o_result holds its value until the next DONE.
- i_rom_data is sampled only in FETCH; a Z/X value outside FETCH has no effect.

Optional Feature:
- Macro: CHEBY_SAT_EN.
- Defined:
  - r is clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1], i.e. 0x8000..0x7FFF.
  - Extra output port o_sat (1 bit, reset 0) is updated at DONE: 1 if the clamp engaged, else 0. It holds until the next DONE.
- Undefined: no o_sat port; o_result is the wrapped low DATA_W bits of r.

Test Plan:
- Reset, then idle check -> c_rom_ce = 0, c_rom_tri_output = 1, o_busy = 0, o_valid = 0, o_result = 0x0000.
- coef[0] = 0x7FFF, others 0; ROM model T = {7FFF, F000, 8400, 2EFF, 703F, B4F0, A284, 626E}; pulse c_start -> o_rom_address steps 0..7 on consecutive cycles with ce = 1, tri = 0; o_valid 10 cycles after the start edge; o_result = 0x7FFE.
- coef[1] = 0x4000 only -> o_result = 0xF800.
- coef[0] = coef[3] = 0x7FFF -> with CHEBY_SAT_EN: o_result = 0x7FFF, o_sat = 1. Without it: o_result = 0xAEFD.
- Second c_start and a coef write to index 0 during FETCH -> both ignored; exactly one o_valid, result unchanged from the previous scenario.
- c_rst_n low at address 4 -> outputs return to reset values asynchronously, no o_valid; a new start afterwards (coefficients now 0) yields o_result = 0x0000.
